// File: rtl/icache_dm_ctrl.sv
// Direct-mapped instruction cache with a blocking single-line refill FSM.
// Register-based tag/data storage, combinational lookup, saturating hit/miss counters.
module icache_dm_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LINE_W    = 128,
    parameter int NUM_LINES = 128,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int WORDS  = LINE_W / DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP,
        S_FLUSH
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [LINE_W-1:0]     data_q [NUM_LINES];
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  hit_q, hit_d;
    logic                  pend_q, pend_d;
    logic [CNT_W-1:0]      hcnt_q, hcnt_d;
    logic [CNT_W-1:0]      mcnt_q, mcnt_d;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic [DATA_W-1:0]     req_word;
    logic [DATA_W-1:0]     fill_word;
    logic                  lookup_hit;
    logic                  fill_we;
    logic                  unused_ok;

    assign req_idx  = cpu_addr[OFF_W +: IDX_W];
    assign req_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx = addr_q[OFF_W +: IDX_W];
    assign fill_tag = addr_q[ADDR_W-1 -: TAG_W];

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Word select views the line as a packed array of CPU words.
    generate
        if (WORDS > 1) begin : g_wsel
            localparam int WSEL_W = OFF_W - BYTE_W;
            logic [WORDS-1:0][DATA_W-1:0] req_line;
            logic [WORDS-1:0][DATA_W-1:0] fill_line;
            logic [WSEL_W-1:0]            req_sel;
            logic [WSEL_W-1:0]            fill_sel;

            assign req_line  = data_q[req_idx];
            assign fill_line = mem_rdata;
            assign req_sel   = cpu_addr[BYTE_W +: WSEL_W];
            assign fill_sel  = addr_q[BYTE_W +: WSEL_W];
            assign req_word  = req_line[req_sel];
            assign fill_word = fill_line[fill_sel];
        end else begin : g_nosel
            assign req_word  = data_q[req_idx];
            assign fill_word = mem_rdata;
        end
    endgenerate

    assign unused_ok = ^{cpu_addr, addr_q};

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        hit_d    = 1'b0;
        pend_d   = pend_q;
        hcnt_d   = hcnt_q;
        mcnt_d   = mcnt_q;
        fill_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (cpu_req) begin
                    if (lookup_hit) begin
                        rvalid_d = 1'b1;
                        hit_d    = 1'b1;
                        rdata_d  = req_word;
                        if (hcnt_q != '1) hcnt_d = hcnt_q + CNT_W'(1);
                    end else begin
                        addr_d  = cpu_addr;
                        state_d = S_REFILL;
                        if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
                    end
                end
            end
            S_REFILL: begin
                if (flush) pend_d = 1'b1;
                if (mem_ready) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    rdata_d           = fill_word;
                    rvalid_d          = 1'b1;
                    state_d           = S_RESP;
                end
            end
            S_RESP: begin
                // A flush seen during the refill still invalidates the new line.
                state_d = (pend_q || flush) ? S_FLUSH : S_IDLE;
                pend_d  = 1'b0;
            end
            S_FLUSH: begin
                valid_d = '0;
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            hit_q    <= 1'b0;
            pend_q   <= 1'b0;
            hcnt_q   <= '0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            hit_q    <= hit_d;
            pend_q   <= pend_d;
            hcnt_q   <= hcnt_d;
            mcnt_q   <= mcnt_d;
        end
    end

    // Tag and data arrays carry no reset; valid_q guards them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[fill_idx] <= mem_rdata;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    assign cpu_ready  = (state_q == S_IDLE) && !flush;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_hit    = hit_q;
    assign mem_req    = (state_q == S_REFILL);
    assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign hit_count  = hcnt_q;
    assign miss_count = mcnt_q;

endmodule
